// File: rtl/metro_mpi_pkg.sv
// Shared constants and types for the metro-mpi credit link layer.
// Default sizes here feed the sender's parameter defaults.
package metro_mpi_pkg;

    localparam int unsigned NUM_CH_DEFAULT     = 2;
    localparam int unsigned DATA_W_DEFAULT     = 64;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
    localparam int unsigned MAX_CREDIT_DEFAULT = 8;
    localparam int unsigned CREDIT_WIDTH       = $clog2(MAX_CREDIT_DEFAULT + 1);
    localparam int unsigned CH_WIDTH           = (NUM_CH_DEFAULT > 1) ? $clog2(NUM_CH_DEFAULT) : 1;

    typedef struct packed {
        logic [CH_WIDTH-1:0]       chan;
        logic [DATA_W_DEFAULT-1:0] data;
    } flit_t;

endpackage

// File: rtl/credit_chan_fifo.sv
// Per-channel synchronous FIFO with full/empty flags; push ignored when full,
// pop ignored when empty. Depth must be a power of two so pointers wrap freely.
module credit_chan_fifo #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/credit_sender_mc.sv
// Multi-channel credit-based flit sender: per-channel FIFOs and credit counters,
// round-robin arbitration onto one registered output port.
module credit_sender_mc
    import metro_mpi_pkg::*;
#(
    parameter  int unsigned NUM_CH     = NUM_CH_DEFAULT,
    parameter  int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter  int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter  int unsigned MAX_CREDIT = MAX_CREDIT_DEFAULT,
    localparam int unsigned CREDIT_W   = $clog2(MAX_CREDIT + 1),
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NUM_CH-1:0]          in_valid_i,
    input  logic [NUM_CH*DATA_W-1:0]   in_data_i,
    output logic [NUM_CH-1:0]          in_ready_o,
    input  logic [NUM_CH-1:0]          yummy_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       valid_o,
    output logic [CH_W-1:0]            chan_o,
    output logic [NUM_CH*CREDIT_W-1:0] credit_o,
    output logic                       overflow_err_o
);

    logic [DATA_W-1:0]   fifo_head [NUM_CH];
    logic [NUM_CH-1:0]   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [NUM_CH-1:0]   eligible;
    logic [CREDIT_W-1:0] credit_q [NUM_CH];
    logic [CREDIT_W-1:0] credit_d [NUM_CH];
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_valid;
    int unsigned         cand;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        assign in_ready_o[c] = !fifo_full[c];
        assign fifo_push[c]  = in_valid_i[c] && !fifo_full[c];
        assign eligible[c]   = !fifo_empty[c] && (credit_q[c] != '0);

        credit_chan_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .push_i  (fifo_push[c]),
            .data_i  (in_data_i[c*DATA_W +: DATA_W]),
            .pop_i   (fifo_pop[c]),
            .head_o  (fifo_head[c]),
            .full_o  (fifo_full[c]),
            .empty_o (fifo_empty[c])
        );
    end

    // Round-robin: first eligible channel at or after the pointer wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_CH;
            if (!grant_valid && eligible[CH_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(cand);
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = CH_W'((32'(grant_idx) + 1) % NUM_CH);
        end
    end

    always_comb begin
        valid_d = grant_valid;
        data_d  = data_q;
        chan_d  = chan_q;
        ovf_d   = ovf_q;
        if (grant_valid) begin
            data_d = fifo_head[grant_idx];
            chan_d = grant_idx;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            fifo_pop[c] = grant_valid && (grant_idx == CH_W'(c));
            credit_d[c] = credit_q[c];
            // A same-cycle send and yummy cancel out.
            if (fifo_pop[c] && !yummy_i[c]) begin
                credit_d[c] = credit_q[c] - CREDIT_W'(1);
            end else if (!fifo_pop[c] && yummy_i[c]) begin
                if (credit_q[c] == CREDIT_W'(MAX_CREDIT)) begin
                    ovf_d = 1'b1;
                end else begin
                    credit_d[c] = credit_q[c] + CREDIT_W'(1);
                end
            end
        end
    end

    always_comb begin
        credit_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            credit_o[c*CREDIT_W +: CREDIT_W] = credit_q[c];
        end
    end

    assign data_o         = data_q;
    assign valid_o        = valid_q;
    assign chan_o         = chan_q;
    assign overflow_err_o = ovf_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr_q <= '0;
            data_q   <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                credit_q[c] <= CREDIT_W'(MAX_CREDIT);
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            for (int c = 0; c < NUM_CH; c++) begin
                credit_q[c] <= credit_d[c];
            end
        end
    end

endmodule

// File: tb/tb_credit_sender_mc.sv
// Bench for credit_sender_mc: scenario tasks plus randomized traffic, all checked
// against a queue-based behavioural model of the sender.
module tb_credit_sender_mc;

    localparam int NCH   = 2;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int MAXC  = 8;
    localparam int MAXC2 = 2;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0]    in_valid = '0, yummy = '0, in_ready;
    logic [NCH*DW-1:0] in_data = '0;
    logic [DW-1:0]     data;
    logic              valid, chan, ovf;
    logic [NCH*4-1:0]  credit;

    logic [NCH-1:0]    in_valid_b = '0, yummy_b = '0, in_ready_b;
    logic [NCH*DW-1:0] in_data_b = '0;
    logic [DW-1:0]     data_b;
    logic              valid_b, chan_b, ovf_b;
    logic [NCH*2-1:0]  credit_b;

    wire [12:0] dut_vec = {valid, chan, credit, ovf, in_ready};

    int n_checks = 0;
    int n_fails  = 0;

    credit_sender_mc #(
        .NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_CREDIT(MAXC)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready), .yummy_i(yummy), .data_o(data), .valid_o(valid),
        .chan_o(chan), .credit_o(credit), .overflow_err_o(ovf)
    );

    credit_sender_mc #(
        .NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_CREDIT(MAXC2)
    ) dut2 (
        .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid_b), .in_data_i(in_data_b),
        .in_ready_o(in_ready_b), .yummy_i(yummy_b), .data_o(data_b), .valid_o(valid_b),
        .chan_o(chan_b), .credit_o(credit_b), .overflow_err_o(ovf_b)
    );

    // Behavioural model of dut: queues of pending flits, integer credits.
    logic [DW-1:0] mq [NCH][$];
    int            mcr [NCH];
    int            mptr, mchan;
    bit            mvalid, movf;
    logic [DW-1:0] mdata;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NCH; c++) begin
                mq[c].delete();
                mcr[c] = MAXC;
            end
            mptr = 0; mvalid = 0; mdata = '0; mchan = 0; movf = 0;
        end else begin
            int g;
            bit acc [NCH];
            for (int c = 0; c < NCH; c++) acc[c] = in_valid[c] && (mq[c].size() < DEPTH);
            g = -1;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (mptr + k) % NCH;
                if (g < 0 && mq[c].size() > 0 && mcr[c] > 0) g = c;
            end
            mvalid = (g >= 0);
            if (g >= 0) begin
                mdata = mq[g].pop_front();
                mchan = g;
                mptr  = (g + 1) % NCH;
            end
            for (int c = 0; c < NCH; c++) begin
                if (acc[c]) mq[c].push_back(in_data[c*DW +: DW]);
                if (g == c) mcr[c] = mcr[c] - 1;
                if (yummy[c]) begin
                    if (g != c && mcr[c] == MAXC) movf = 1;
                    else mcr[c] = mcr[c] + 1;
                end
            end
        end
    end

    function automatic logic [12:0] model_vec();
        logic [1:0] rdy;
        for (int c = 0; c < NCH; c++) rdy[c] = (mq[c].size() < DEPTH);
        return {mvalid, 1'(mchan), 4'(mcr[1]), 4'(mcr[0]), movf, rdy};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; in_valid = '0; yummy = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dut_vec !== 13'b0_0_1000_1000_0_11 || data !== '0) begin
            n_fails++;
            $display("FAIL reset_state got %h data %h required %h data 0", dut_vec, data,
                     13'b0_0_1000_1000_0_11);
        end
        n_checks++;
        if (credit_b !== 4'b1010 || valid_b !== 1'b0 || in_ready_b !== 2'b11) begin
            n_fails++;
            $display("FAIL reset_state_b credit %b valid %b ready %b required 1010 0 11",
                     credit_b, valid_b, in_ready_b);
        end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d [2];
        int nsend = 0;
        exp_d[0] = 64'hCAFE_CAFE_CAFE_CAFE;
        exp_d[1] = 64'hCAFE_CAFE_CAFE_CAFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec() || data !== mdata) begin
                n_fails++;
                $display("FAIL basic_model cyc %0d got %h/%h required %h/%h", i, dut_vec, data,
                         model_vec(), mdata);
            end
            if (valid === 1'b1) begin
                n_checks++;
                if (nsend >= 2 || data !== exp_d[nsend] || chan !== 1'b0 ||
                    credit[3:0] !== 4'(MAXC - 1 - nsend)) begin
                    n_fails++;
                    $display("FAIL basic_send #%0d got data %h chan %b credit %0d", nsend, data,
                             chan, credit[3:0]);
                end
                nsend++;
            end
            in_valid = (i < 2) ? 2'b01 : 2'b00;
            if (i < 2) in_data[DW-1:0] = exp_d[i];
        end
        n_checks++;
        if (nsend != 2) begin
            n_fails++;
            $display("FAIL basic_count got %0d sends required 2", nsend);
        end
    endtask

    task automatic test_credit_limit();
        int sends = 0;
        logic [DW-1:0] last = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (valid_b === 1'b1) sends++;
            in_valid_b = (i < 4) ? 2'b01 : 2'b00;
            in_data_b[DW-1:0] = 64'(i + 1);
        end
        n_checks++;
        if (sends != 2 || credit_b[1:0] !== 2'd0 || valid_b !== 1'b0) begin
            n_fails++;
            $display("FAIL credit_limit got %0d sends credit %0d required 2 sends credit 0",
                     sends, credit_b[1:0]);
        end
        @(negedge clk);
        yummy_b = 2'b01;
        @(negedge clk);
        yummy_b = 2'b00;
        sends = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_b === 1'b1) begin
                sends++;
                last = data_b;
            end
        end
        n_checks++;
        if (sends != 1 || last !== 64'd3 || credit_b[1:0] !== 2'd0) begin
            n_fails++;
            $display("FAIL credit_refill got %0d sends data %h credit %0d required 1 3 0",
                     sends, last, credit_b[1:0]);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec() || data !== mdata) begin
                n_fails++;
                $display("FAIL b2b_model cyc %0d got %h/%h required %h/%h", i, dut_vec, data,
                         model_vec(), mdata);
            end
            if (valid === 1'b1 && first < 0) first = i;
            if (first >= 0 && i - first < 8) begin
                n_checks++;
                if (valid !== 1'b1 || chan !== 1'((i - first) % 2)) begin
                    n_fails++;
                    $display("FAIL b2b_alternate cyc %0d got valid %b chan %b required 1 %0d",
                             i, valid, chan, (i - first) % 2);
                end
            end
            in_valid = (i < 10) ? 2'b11 : 2'b00;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        n_checks++;
        if (first != 2) begin
            n_fails++;
            $display("FAIL b2b_latency first valid at cycle %0d required 2", first);
        end
    endtask

    task automatic test_credit_accounting();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec() || data !== mdata) begin
                n_fails++;
                $display("FAIL acct_model cyc %0d got %h/%h required %h/%h", i, dut_vec, data,
                         model_vec(), mdata);
            end
            in_valid = (i < 5) ? 2'b10 : 2'b00;
            in_data[DW +: DW] = {$urandom, $urandom};
        end
        n_checks++;
        if (credit[7:4] !== 4'd3) begin
            n_fails++;
            $display("FAIL acct_drain credit1 got %0d required 3", credit[7:4]);
        end
        in_valid = 2'b10;
        @(negedge clk);
        in_valid = 2'b00;
        yummy    = 2'b10;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || chan !== 1'b1 || credit[7:4] !== 4'd3) begin
            n_fails++;
            $display("FAIL acct_send_yummy got valid %b chan %b credit1 %0d required 1 1 3",
                     valid, chan, credit[7:4]);
        end
        yummy = 2'b01;
        @(negedge clk);
        yummy = 2'b00;
        n_checks++;
        if (credit[3:0] !== 4'd8 || ovf !== 1'b1) begin
            n_fails++;
            $display("FAIL acct_overflow got credit0 %0d ovf %b required 8 1", credit[3:0], ovf);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (ovf !== 1'b1 || dut_vec !== model_vec()) begin
                n_fails++;
                $display("FAIL acct_sticky cyc %0d got %h required %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] got_q [$];
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec() || data !== mdata) begin
                n_fails++;
                $display("FAIL full_model cyc %0d got %h/%h required %h/%h", i, dut_vec, data,
                         model_vec(), mdata);
            end
            in_valid = (i < 8) ? 2'b01 : 2'b00;
            in_data[DW-1:0] = {$urandom, $urandom};
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 2'b01;
            in_data[DW-1:0] = {$urandom, $urandom};
            exp_q.push_back(in_data[DW-1:0]);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready[0] !== 1'b0 || credit[3:0] !== 4'd0) begin
            n_fails++;
            $display("FAIL full_ready got ready0 %b credit0 %0d required 0 0", in_ready[0],
                     credit[3:0]);
        end
        in_data[DW-1:0] = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        in_valid = 2'b00;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec() || data !== mdata) begin
                n_fails++;
                $display("FAIL full_drain_model cyc %0d got %h/%h required %h/%h", i, dut_vec,
                         data, model_vec(), mdata);
            end
            if (valid === 1'b1) got_q.push_back(data);
            yummy = (i < 4) ? 2'b01 : 2'b00;
        end
        n_checks++;
        if (got_q.size() != 4 || got_q != exp_q) begin
            n_fails++;
            $display("FAIL full_order got %0d flits required 4 in push order", got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 5) begin
                in_valid = 2'b11;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        n_checks++;
        if (valid !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_inflight got valid %b required 1", valid);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_async_drop got valid %b required 0", valid);
        end
        @(negedge clk);
        rstn = 1'b1; in_valid = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== 13'b0_0_1000_1000_0_11 || data !== '0) begin
                n_fails++;
                $display("FAIL mid_after_reset cyc %0d got %h data %h required %h data 0", i,
                         dut_vec, data, 13'b0_0_1000_1000_0_11);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec() || data !== mdata) begin
                n_fails++;
                $display("FAIL random_model cyc %0d got %h/%h required %h/%h", i, dut_vec, data,
                         model_vec(), mdata);
            end
            for (int c = 0; c < NCH; c++) begin
                in_valid[c] = ($urandom_range(0, 2) != 0);
                yummy[c]    = ($urandom_range(0, 2) == 0) && (mcr[c] < MAXC);
            end
            in_data = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    initial begin
        test_reset();
        test_credit_limit();
        test_basic();
        test_back_to_back();
        test_credit_accounting();
        test_fifo_full();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/credit_sender_mc.md
Name: credit_sender_mc

Overview:
- Multi-channel, parametrised credit-based flit sender for the metro-mpi link layer.
- Each channel owns an input FIFO and a credit counter replenished by per-channel yummy pulses.
- A round-robin arbiter picks one eligible channel per cycle and drives a single registered output port (data, valid, channel id) toward the MPI bridge.
- Generalises the single-channel, single-credit sender: configurable width, depth and credit limit, correct simultaneous send/yummy accounting, and error reporting.

Parameters:
- NUM_CH, 2, number of independent source channels (>=1).
- DATA_W, 64, flit width in bits.
- FIFO_DEPTH, 4, entries per channel FIFO (power of two, >=2).
- MAX_CREDIT, 8, credits per channel after reset; receiver buffer depth.
- CREDIT_W, $clog2(MAX_CREDIT+1), derived credit counter width; not overridden.
- CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), derived channel index width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset. Asynchronous, active-low; all state cleared while low.
- in_valid_i  in  NUM_CH  per-channel flit valid.
- in_data_i  in  NUM_CH*DATA_W  per-channel flit data; channel c occupies bits [c*DATA_W +: DATA_W].
- in_ready_o  out  NUM_CH  per-channel FIFO not full.
- yummy_i  in  NUM_CH  one-cycle credit-return pulse per channel; one credit per pulse.
- data_o  out  DATA_W  registered output flit.
- valid_o  out  1  registered; high for exactly one cycle per flit sent.
- chan_o  out  CH_W  channel index of the flit on data_o.
- credit_o  out  NUM_CH*CREDIT_W  current credit count per channel (debug/monitor).
- overflow_err_o  out  1  sticky; set when a yummy arrives at a channel already holding MAX_CREDIT.

Behaviour:
- Reset values: in_ready_o all 1, valid_o 0, data_o 0, chan_o 0, every credit = MAX_CREDIT, overflow_err_o 0, FIFOs empty, round-robin pointer 0.
- Reset asserted mid-operation: FIFO contents discarded, in-flight output dropped (valid_o falls immediately), all credits restored to MAX_CREDIT. No partial state survives.
- Input handshake:
  - Push into channel c FIFO when in_valid_i[c] & in_ready_o[c].
  - in_ready_o[c] = !full[c]; no dependence on in_valid_i.
  - No bypass path.
- Eligibility: channel c is eligible iff FIFO c is non-empty and credit[c] != 0.
- Arbitration:
  - Round-robin, search starting at pointer p, wrapping modulo NUM_CH.
  - On a grant to channel g, p <= (g+1) mod NUM_CH.
  - With no grant, p holds.
  - At most one grant per cycle.
- Send: on grant, at the next edge:
  - FIFO g pops.
  - data_o <= head; chan_o <= g; valid_o <= 1.
- With no grant: valid_o <= 0. data_o and chan_o hold their last values.
- Latency: a flit pushed at edge E into an empty FIFO, with credit available and no competition, is granted in cycle E..E+1 and appears with valid_o=1 after edge E+1 (2-cycle minimum). Throughput: 1 flit/cycle aggregate.
- Credit update per channel each cycle: credit_next = credit - sent[c] + yummy_i[c].
  - Simultaneous send and yummy: count unchanged.
  - Send only possible when credit >= 1, so no underflow.
  - yummy_i[c] at credit == MAX_CREDIT without a same-cycle send: credit saturates at MAX_CREDIT, overflow_err_o <= 1 (sticky until reset).
- FIFO boundaries:
  - Push and pop in the same cycle on a full FIFO is not allowed, since ready is 0.
  - Push and pop on a non-full, non-empty FIFO: occupancy unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- The block contains no DPI calls. The MPI bridge consumes valid_o/data_o/chan_o and drives yummy_i.

Decomposition:
- metro_mpi_pkg: add MAX_CREDIT_DEFAULT, a flit struct typedef {logic [CH_W-1:0] chan; logic [DATA_W-1:0] data} sized from package constants, and the existing CREDIT_WIDTH, aligned to CREDIT_W.
- One sub-module: credit_chan_fifo. It is a parametrised synchronous FIFO (DATA_W, FIFO_DEPTH) with full/empty outputs, instantiated NUM_CH times.
- The arbiter and credit counters stay in the top module.

Test Plan:
- Reset, then channel 0 pushes 0xCAFE_CAFE_CAFE_CAFE and 0xCAFE_CAFE_CAFE_CAFF; no yummy. Required: valid_o pulses twice with those values in order and chan_o=0; credit_o[0] goes 8→7→6.
- MAX_CREDIT=2, push 4 flits on ch0 with no yummy. Required: exactly 2 sends, then valid_o stays 0. One yummy pulse → exactly 1 more send.
- Both channels continuously loaded with ample credit. Required: chan_o alternates 0,1,0,1; valid_o high every cycle.
- Same-cycle send and yummy on ch1 at credit 3. Required: credit_o[1] stays 3. Yummy at credit 8 with no send. Required: credit stays 8, overflow_err_o=1 and stays set.
- Fill ch0 FIFO (4 entries) with credit 0. Required: in_ready_o[0]=0 and the 5th in_valid_i is not accepted; after yummy, all 4 flits drain in FIFO order.
- Assert rstn_i low while both FIFOs hold 3 flits. Required: valid_o=0 immediately; after release, credits=8, in_ready_o=all 1, and no stale flit is emitted.
